// File: rtl/ingress_if.sv
// ingress_if -- handshake and fifo-side bus of one ingress_checker port.
//   in_valid / in_ready / in_data : upstream packet handshake
//   fifo_full                     : downstream fifo status
//   fifo_wr_en / fifo_wr_data     : fifo write strobe and packet
// modport master : the side that supplies packets and fifo status
// modport slave  : the ingress_checker itself
interface ingress_if #(
  parameter int PACKET_WIDTH = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [PACKET_WIDTH-1:0] in_data;
  logic                    fifo_full;
  logic                    fifo_wr_en;
  logic [PACKET_WIDTH-1:0] fifo_wr_data;

  modport master (
    output in_valid,
    output in_data,
    output fifo_full,
    input  in_ready,
    input  fifo_wr_en,
    input  fifo_wr_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  fifo_full,
    output in_ready,
    output fifo_wr_en,
    output fifo_wr_data
  );
endinterface

// File: rtl/ingress_checker.sv
// ingress_checker -- per-port ingress stage in front of the port fifo.
// Accepts one packet at a time, checks its header (source, one-hot target)
// and either writes it to the fifo or drops it with a pulse, a saturating
// drop counter and a sticky reason code. Stalls while the fifo is full.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous, active-high reset
//   bus        : ingress_if.slave (in_valid/in_ready/in_data, fifo_full,
//                fifo_wr_en/fifo_wr_data)
//   drop_pulse : one-cycle pulse per dropped packet
//   drop_count : saturating count of dropped packets
//   err_code   : reason for the last drop (1 bad target, 2 self-send,
//                3 wrong source, 4 fifo-full timeout), sticky
//
// Optional feature: define INGRESS_TIMEOUT_EN to drop a packet that has
// stalled in WAIT for TIMEOUT consecutive fifo-full cycles (err_code 4).
module ingress_checker #(
  parameter int PACKET_WIDTH = 16,
  parameter int PORT_ID      = 0,
  parameter int CNT_WIDTH    = 8,
  parameter int TIMEOUT      = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  ingress_if.slave             bus,
  output logic                 drop_pulse,
  output logic [CNT_WIDTH-1:0] drop_count,
  output logic [2:0]           err_code
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [3:0] SELF_TARGET = 4'(1 << PORT_ID);
  localparam logic [3:0] OWN_SOURCE  = 4'(PORT_ID);

  state_t                  state;
  logic                    ready_r;
  logic [PACKET_WIDTH-1:0] hold;
  logic [2:0]              hold_err;
  logic                    wr;
  logic                    drop;
  logic [2:0]              drop_code;

`ifdef INGRESS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
`endif

  // Header check; the first failing rule decides the reason code.
  function automatic logic [2:0] check_err(input logic [PACKET_WIDTH-1:0] pkt);
    logic [3:0] tgt;
    logic [3:0] src;
    tgt = pkt[7:4];
    src = pkt[3:0];
    if ((tgt == 4'd0) || ((tgt & (tgt - 4'd1)) != 4'd0))
      return 3'd1;
    else if (tgt == SELF_TARGET)
      return 3'd2;
    else if (src != OWN_SOURCE)
      return 3'd3;
    else
      return 3'd0;
  endfunction

  assign hold_err = check_err(hold);

  // Write/drop decisions use fifo_full of the current cycle, so they are
  // combinational from the state and the hold register.
  always_comb begin
    wr        = 1'b0;
    drop      = 1'b0;
    drop_code = 3'd0;
    case (state)
      CHECK: begin
        if (hold_err != 3'd0) begin
          drop      = 1'b1;
          drop_code = hold_err;
        end else if (!bus.fifo_full) begin
          wr = 1'b1;
        end
      end
      WAIT: begin
        if (!bus.fifo_full) begin
          wr = 1'b1;
`ifdef INGRESS_TIMEOUT_EN
        end else if (wait_cnt == TW'(TIMEOUT)) begin
          drop      = 1'b1;
          drop_code = 3'd4;
`endif
        end
      end
      default: ;
    endcase
  end

  assign bus.in_ready     = ready_r;
  assign bus.fifo_wr_en   = wr;
  assign bus.fifo_wr_data = hold;
  assign drop_pulse       = drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ready_r    <= 1'b1;
      hold       <= '0;
      drop_count <= '0;
      err_code   <= 3'd0;
`ifdef INGRESS_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            hold    <= bus.in_data;
            ready_r <= 1'b0;
            state   <= CHECK;
          end
        end
        CHECK: begin
          if (wr || drop) begin
            ready_r <= 1'b1;
            state   <= IDLE;
          end else begin
            state <= WAIT;
`ifdef INGRESS_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        WAIT: begin
          if (wr || drop) begin
            ready_r <= 1'b1;
            state   <= IDLE;
`ifdef INGRESS_TIMEOUT_EN
          end else if (wait_cnt != TW'(TIMEOUT)) begin
            wait_cnt <= wait_cnt + TW'(1);
`endif
          end
        end
        default: begin
          ready_r <= 1'b1;
          state   <= IDLE;
        end
      endcase

      if (drop) begin
        if (drop_count != {CNT_WIDTH{1'b1}})
          drop_count <= drop_count + CNT_WIDTH'(1);
        err_code <= drop_code;
      end
    end
  end

endmodule

// File: tb/tb_ingress_checker.sv
module tb_ingress_checker;

  localparam int PW      = 16;
  localparam int PID     = 0;
  localparam int CW      = 2;
  localparam int TIMEOUT = 4;
`ifdef INGRESS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          drop_pulse;
  logic [CW-1:0] drop_count;
  logic [2:0]    err_code;

  ingress_if #(.PACKET_WIDTH(PW)) bus ();

  ingress_checker #(
    .PACKET_WIDTH(PW),
    .PORT_ID     (PID),
    .CNT_WIDTH   (CW),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .drop_pulse(drop_pulse),
    .drop_count(drop_count),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: transaction-level view of one outstanding packet.
  bit          pend;      // a packet has been accepted and not yet resolved
  logic [15:0] pkt;       // last accepted packet (what fifo_wr_data shows)
  int          k;         // 1 = first cycle after acceptance, 2 = second, ...
  int          exp_cnt;
  int          exp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int hdr_err(input logic [15:0] p);
    int ones = 0;
    int tgt  = (int'(p) >> 4) & 15;
    for (int b = 0; b < 4; b++) ones += (tgt >> b) & 1;
    if (ones != 1) return 1;
    if (tgt == (1 << PID)) return 2;
    if ((int'(p) & 15) != PID) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    pend    = 1'b0;
    pkt     = 16'h0;
    k       = 0;
    exp_cnt = 0;
    exp_err = 0;
  endtask

  // One clock cycle: drive inputs, check the cycle's outputs, clock, then
  // check the registered counters against the model.
  task automatic cycle(input logic v, input logic [15:0] d, input logic f);
    int   e;
    bit   ewr;
    bit   edrop;
    int   ecode;
    bit   was_pend;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.fifo_full = f;
    #1;
    ewr = 0; edrop = 0; ecode = 0;
    was_pend = pend;
    if (pend) begin
      e = hdr_err(pkt);
      if (k == 1 && e != 0) begin
        edrop = 1; ecode = e;
      end else if (!f) begin
        ewr = 1;
      end else if (TO_EN && k == TIMEOUT + 2) begin
        edrop = 1; ecode = 4;
      end
    end
    chk("in_ready", 32'(bus.in_ready), 32'(!pend));
    chk("fifo_wr_en", 32'(bus.fifo_wr_en), 32'(ewr));
    chk("drop_pulse", 32'(drop_pulse), 32'(edrop));
    chk("fifo_wr_data", 32'(bus.fifo_wr_data), 32'(pkt));
    @(posedge clk);
    #1;
    if (ewr || edrop) pend = 1'b0;
    else if (pend) k++;
    if (edrop) begin
      if (exp_cnt < (1 << CW) - 1) exp_cnt++;
      exp_err = ecode;
    end
    if (!was_pend && v) begin
      pend = 1'b1; pkt = d; k = 1;
    end
    chk("drop_count", 32'(drop_count), 32'(exp_cnt));
    chk("err_code", 32'(err_code), 32'(exp_err));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_wr_en"}, 32'(bus.fifo_wr_en), 32'd0);
    chk({tag, "_wr_data"}, 32'(bus.fifo_wr_data), 32'd0);
    chk({tag, "_drop"}, 32'(drop_pulse), 32'd0);
    chk({tag, "_count"}, 32'(drop_count), 32'd0);
    chk({tag, "_err"}, 32'(err_code), 32'd0);
  endtask

  // Asynchronous reset asserted mid-cycle, released one edge later.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    bus.fifo_full = 1'b0;
    bus.in_valid  = 1'b0;
    #1;
    check_reset_outputs(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [15:0] rand_pkt();
    logic [3:0] tgt;
    logic [3:0] src;
    logic [5:0] pay;
    logic [1:0] typ;
    case ($urandom_range(0, 5))
      0: tgt = 4'(($urandom_range(0, 15)));
      1: tgt = 4'b0001;
      2: tgt = 4'b0010;
      3: tgt = 4'b0100;
      default: tgt = 4'b1000;
    endcase
    src = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'(PID);
    pay = 6'($urandom);
    typ = 2'($urandom);
    return {pay, typ, tgt, src};
  endfunction

  initial begin
    int burst;
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0;
    bus.fifo_full = 1'b0;
    model_reset();
    #2;
    do_reset("rst0");

    // Legal packet, fifo free: write one cycle after handshake.
    cycle(1'b1, 16'h0120, 1'b0);
    cycle(1'b0, 16'h0, 1'b0);
    chk("legal_count_zero", 32'(drop_count), 32'd0);
    cycle(1'b0, 16'h0, 1'b0);

    // Illegal packets: bad target, self-send, wrong source, then saturation.
    cycle(1'b1, 16'h0130, 1'b0);
    cycle(1'b0, 16'h0, 1'b0);
    chk("err_target", 32'(err_code), 32'd1);
    cycle(1'b1, 16'h0110, 1'b0);
    cycle(1'b0, 16'h0, 1'b0);
    chk("err_self", 32'(err_code), 32'd2);
    cycle(1'b1, 16'h0121, 1'b0);
    cycle(1'b0, 16'h0, 1'b0);
    chk("err_source", 32'(err_code), 32'd3);
    chk("count_three", 32'(drop_count), 32'd3);
    cycle(1'b1, 16'h0000, 1'b0);
    cycle(1'b0, 16'h0, 1'b0);
    cycle(1'b1, 16'h01F0, 1'b0);
    cycle(1'b0, 16'h0, 1'b0);
    chk("count_saturated", 32'(drop_count), 32'd3);
    chk("err_sticky", 32'(err_code), 32'd1);

    // Stall: fifo full for 5 cycles, falls on the 6th; in_valid while busy ignored.
    do_reset("rst1");
    cycle(1'b1, 16'h0140, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'h0150, 1'b1);
    cycle(1'b0, 16'h0, 1'b0);
    cycle(1'b0, 16'h0, 1'b0);

    // Timeout behaviour (or indefinite stall without the feature).
    do_reset("rst2");
    cycle(1'b1, 16'h0120, 1'b1);
    for (int i = 0; i < (TO_EN ? TIMEOUT + 2 : 100); i++) cycle(1'b0, 16'h0, 1'b1);
    if (TO_EN) chk("timeout_err", 32'(err_code), 32'd4);
    else       chk("no_timeout_count", 32'(drop_count), 32'd0);
    cycle(1'b0, 16'h0, 1'b0);
    cycle(1'b0, 16'h0, 1'b0);

    // Reset while stalled in WAIT: held packet never written, not counted.
    do_reset("rst3");
    cycle(1'b1, 16'h0180, 1'b1);
    cycle(1'b0, 16'h0, 1'b1);
    cycle(1'b0, 16'h0, 1'b1);
    #3;
    do_reset("rst_wait");
    for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0, 1'b0);

    // Randomized traffic with occasional long full bursts.
    burst = 0;
    for (int i = 0; i < 600; i++) begin
      if (burst == 0 && $urandom_range(0, 40) == 0) burst = $urandom_range(3, 9);
      if (burst > 0) begin
        cycle($urandom_range(0, 3) != 0, rand_pkt(), 1'b1);
        burst--;
      end else begin
        cycle($urandom_range(0, 3) != 0, rand_pkt(), $urandom_range(0, 2) == 0);
      end
      if (i == 300) do_reset("rst_mid");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ingress_checker.md
Name: ingress_checker

Overview:
Per-port ingress stage sitting directly upstream of the port fifo in the 4-port switch. It accepts packets from the port interface over a valid/ready handshake and checks each header (source, target). Legal packets are written into the fifo; illegal packets are dropped with a pulse, a saturating drop counter and a sticky reason code. It stalls while the fifo is full.

Parameters:
PACKET_WIDTH, 16, packet width; [3:0] source, [7:4] target (one-hot), [9:8] pkt_type, rest payload
PORT_ID, 0, index (0-3) of the port this instance serves
CNT_WIDTH, 8, width of drop_count
TIMEOUT, 64, full-stall cycles before forced drop (used only with the optional feature)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream packet valid
in_ready  output  1  block can accept a packet
in_data  input  PACKET_WIDTH  upstream packet
fifo_full  input  1  downstream fifo full
fifo_wr_en  output  1  fifo write strobe
fifo_wr_data  output  PACKET_WIDTH  packet written to fifo
drop_pulse  output  1  one-cycle pulse per dropped packet
drop_count  output  CNT_WIDTH  saturating count of dropped packets
err_code  output  3  reason for the last drop (sticky)

Behaviour:
- One clock (clk). Reset rst is asynchronous and active-high.
- Reset values:
  - state=IDLE, in_ready=1, fifo_wr_en=0, fifo_wr_data=0, drop_pulse=0, drop_count=0, err_code=0, hold register=0.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture in_data into the hold register and go to CHECK.
  - CHECK: in_ready=0. Outputs are combinational from the hold register.
    - Illegal packet: drop_pulse=1, then IDLE.
    - Legal and !fifo_full: fifo_wr_en=1, fifo_wr_data=hold, then IDLE.
    - Legal and fifo_full: go to WAIT.
  - WAIT: in_ready=0, fifo_wr_en=0 while fifo_full. In the first cycle with !fifo_full: fifo_wr_en=1, then IDLE.
- Check priority, first failure wins:
  - target not exactly one-hot (0 or ≥2 bits set): err 1.
  - target == (1<<PORT_ID), i.e. self-send: err 2.
  - source != PORT_ID: err 3.
- Latency:
  - Handshake at cycle T gives write or drop at T+1 if not stalled.
  - Peak throughput is 1 packet per 2 cycles.
- drop_count and err_code update on the clock edge that ends the drop_pulse cycle.
- drop_count saturates at 2^CNT_WIDTH-1, with no wrap.
- err_code holds its value until the next drop; it is never cleared except by reset.
- fifo_wr_data holds the hold register in all states; it is meaningful only while fifo_wr_en=1.
- fifo_full toggling in CHECK/WAIT: decisions use fifo_full sampled in the same cycle. Exactly one write per legal packet, never duplicated.
- in_valid while in_ready=0 is ignored. Upstream must hold data until accepted.
- Reset mid-packet (CHECK/WAIT): the held packet is discarded with no write and no drop count; the block returns to IDLE immediately.
- Never assert fifo_wr_en and drop_pulse in the same cycle.

Optional Feature:
Macro INGRESS_TIMEOUT_EN.
- Defined: a counter runs in WAIT and clears on entry.
  - If TIMEOUT consecutive cycles pass with fifo_full=1, drop the packet: drop_pulse=1, drop_count++, err_code=4, then IDLE.
  - If fifo_full deasserts on the same cycle the timeout is reached, the write wins.
- Undefined: WAIT stalls indefinitely, and err_code value 4 is never produced.

Test Plan:
- PORT_ID=0, fifo_full=0, in_data=16'h0120 -> one cycle after the handshake: fifo_wr_en=1, fifo_wr_data=16'h0120; drop_count stays 0.
- in_data=16'h0130 (target=0011) -> drop_pulse=1 for one cycle, err_code=1, drop_count=1, no write. Then 16'h0110 (self) -> err_code=2, drop_count=2. Then 16'h0121 (src=1) -> err_code=3, drop_count=3.
- fifo_full=1 during CHECK for 5 cycles with in_data=16'h0140 -> in_ready=0 and no write for 5 cycles; exactly one write of 16'h0140 in the cycle fifo_full falls; in_ready=1 the next cycle.
- CNT_WIDTH=2, send 5 illegal packets -> drop_count reads 1,2,3,3,3.
- Assert rst while in WAIT holding 16'h0180 -> all outputs go to reset values asynchronously; after release, fifo_wr_en is never asserted for 16'h0180.
- With INGRESS_TIMEOUT_EN, TIMEOUT=4, fifo_full held at 1 -> drop_pulse exactly 4 cycles after entering WAIT, err_code=4. Without the macro -> no drop after 100 cycles.
